// File: rtl/shift_ser_arb.sv
// Two-requester round-robin arbiter feeding a single framed serial shifter.
// A granted word is loaded on the accept edge, shifted out one bit per clock, then followed by a one-cycle gap.
module shift_ser_arb #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             ser_id,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n, sreg_shift, word;
    logic [CW-1:0]    cnt, cnt_n;
    logic             last_grant, last_grant_n;
    logic             ser_out_n, ser_frame_n, ser_id_n, done_n;
    logic             grant0, grant1;

    // On contention the requester that did not win last time is preferred.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = (state == IDLE) && grant0 && !rst;
    assign req1_ready = (state == IDLE) && grant1 && !rst;
    assign busy       = (state != IDLE);

    // ser_out is registered, so the first bit is presented from the word itself
    // on the accept edge and later bits come from the already-shifted register.
    always_comb begin
        state_n      = state;
        sreg_n       = sreg;
        cnt_n        = cnt;
        last_grant_n = last_grant;
        ser_out_n    = 1'b0;
        ser_frame_n  = 1'b0;
        ser_id_n     = ser_id;
        done_n       = 1'b0;
        word         = grant0 ? req0_data : req1_data;
        sreg_shift   = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
        case (state)
            IDLE: begin
                if (grant0 || grant1) begin
                    sreg_n       = word;
                    ser_out_n    = MSB_FIRST ? word[WIDTH-1] : word[0];
                    ser_frame_n  = 1'b1;
                    ser_id_n     = grant1;
                    last_grant_n = grant1;
                    cnt_n        = CW'(WIDTH - 1);
                    state_n      = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    done_n  = 1'b1;
                    state_n = GAP;
                end else begin
                    sreg_n      = sreg_shift;
                    ser_out_n   = MSB_FIRST ? sreg_shift[WIDTH-1] : sreg_shift[0];
                    ser_frame_n = 1'b1;
                    cnt_n       = cnt - 1'b1;
                end
            end
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            last_grant <= 1'b1;
            ser_out    <= 1'b0;
            ser_frame  <= 1'b0;
            ser_id     <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            sreg       <= sreg_n;
            cnt        <= cnt_n;
            last_grant <= last_grant_n;
            ser_out    <= ser_out_n;
            ser_frame  <= ser_frame_n;
            ser_id     <= ser_id_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_shift_ser_arb.sv
// Bench for shift_ser_arb: vector table, directed corner sequences, and a random run against a frame-position model.
module tb_shift_ser_arb;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         v0, v1, r0, r1, so, sf, sid, dn, bz;
    logic [W-1:0] d0, d1;
    logic         lv0, lv1, lr0, lr1, lso, lsf, lsid, ldn, lbz;
    logic [W-1:0] ld0, ld1;

    int n_checks = 0;
    int n_fail   = 0;

    shift_ser_arb #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
        .ser_out(so), .ser_frame(sf), .ser_id(sid), .done(dn), .busy(bz)
    );

    shift_ser_arb #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst),
        .req0_valid(lv0), .req0_data(ld0), .req0_ready(lr0),
        .req1_valid(lv1), .req1_data(ld1), .req1_ready(lr1),
        .ser_out(lso), .ser_frame(lsf), .ser_id(lsid), .done(ldn), .busy(lbz)
    );

    typedef struct {
        logic         v0, v1;
        logic [W-1:0] d0, d1;
        logic         er0, er1;
        logic         eid;
        logic [W-1:0] ebits;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string n, input logic eo, input logic ef, input logic eid,
                           input logic ed, input logic eb);
        chk({n, ".ser_out"}, so, eo);
        chk({n, ".ser_frame"}, sf, ef);
        chk({n, ".ser_id"}, sid, eid);
        chk({n, ".done"}, dn, ed);
        chk({n, ".busy"}, bz, eb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; lv0 = 1'b0; lv1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Starts in the cycle after the accept edge; ends in the first IDLE cycle after the gap.
    task automatic collect(input string name, input logic eid, input logic [W-1:0] bits);
        for (int k = 0; k < W; k++) begin
            #1;
            chk_out($sformatf("%s.bit%0d", name, k), bits[W-1-k], 1'b1, eid, 1'b0, 1'b1);
            tick();
        end
        #1;
        chk_out({name, ".gap"}, 1'b0, 1'b0, eid, 1'b1, 1'b1);
        tick();
    endtask

    task automatic wait_accept(input string name, input int limit, output int who, output int waited);
        who = -1;
        waited = 0;
        for (int i = 0; i < limit; i++) begin
            #1;
            if (v0 && r0) begin who = 0; break; end
            if (v1 && r1) begin who = 1; break; end
            tick();
            waited++;
        end
        if (who < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no accept within %0d cycles", name, limit);
        end
    endtask

    int           who, waited;
    int           acc_cyc[$];
    int           acc_who[$];
    logic [W-1:0] l_exp;
    int           m_pos, m_id, m_last;
    logic [W-1:0] m_word;
    logic         e_r0, e_r1, e_frame, e_out;

    initial begin
        tbl[0] = '{v0:1, v1:0, d0:8'hA5, d1:8'h00, er0:1, er1:0, eid:0, ebits:8'hA5};
        tbl[1] = '{v0:0, v1:1, d0:8'h00, d1:8'h3C, er0:0, er1:1, eid:1, ebits:8'h3C};
        tbl[2] = '{v0:1, v1:1, d0:8'h0F, d1:8'hF0, er0:1, er1:0, eid:0, ebits:8'h0F};
        tbl[3] = '{v0:1, v1:1, d0:8'hFF, d1:8'h00, er0:1, er1:0, eid:0, ebits:8'hFF};
        tbl[4] = '{v0:0, v1:1, d0:8'h55, d1:8'h80, er0:0, er1:1, eid:1, ebits:8'h80};
        tbl[5] = '{v0:1, v1:0, d0:8'h01, d1:8'hAA, er0:1, er1:0, eid:0, ebits:8'h01};

        // Reset held with both requesters asking.
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
        lv0 = 1'b0; lv1 = 1'b0; ld0 = '0; ld1 = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst.ready0", r0, 1'b0);
            chk("rst.ready1", r1, 1'b0);
            tick();
            chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        tick();

        // Single 0xA5 word: bits C+1..C+8, done only at C+9, ready again at C+10.
        v0 = 1'b1; d0 = 8'hA5;
        #1;
        chk("a5.accept", r0, 1'b1);
        tick();
        v0 = 1'b0; d0 = 8'h00;
        for (int k = 0; k < W; k++) begin
            l_exp = 8'hA5;
            #1;
            chk_out($sformatf("a5.bit%0d", k), l_exp[W-1-k], 1'b1, 1'b0, 1'b0, 1'b1);
            tick();
        end
        v0 = 1'b1; d0 = 8'h3C;
        #1;
        chk_out("a5.gap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("a5.gap_ready", r0, 1'b0);
        tick();
        #1;
        chk("a5.ready_c10", r0, 1'b1);
        chk("a5.done_c10", dn, 1'b0);
        chk("a5.busy_c10", bz, 1'b0);
        v0 = 1'b0;

        // Table of single frames, each from a fresh reset.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            v0 = tbl[i].v0; v1 = tbl[i].v1; d0 = tbl[i].d0; d1 = tbl[i].d1;
            #1;
            chk($sformatf("vec%0d.ready0", i), r0, tbl[i].er0);
            chk($sformatf("vec%0d.ready1", i), r1, tbl[i].er1);
            tick();
            v0 = 1'b0; v1 = 1'b0; d0 = ~d0; d1 = ~d1;
            collect($sformatf("vec%0d", i), tbl[i].eid, tbl[i].ebits);
        end

        // Contention from reset: req0 first, req1 granted at C+10.
        do_reset();
        v0 = 1'b1; v1 = 1'b1; d0 = 8'h0F; d1 = 8'hF0;
        wait_accept("cont", 4, who, waited);
        chk("cont.first_who", who, 0);
        chk("cont.first_wait", waited, 0);
        tick();
        collect("cont.f0", 1'b0, 8'h0F);
        #1;
        chk("cont.c10_ready0", r0, 1'b0);
        chk("cont.c10_ready1", r1, 1'b1);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        collect("cont.f1", 1'b1, 8'hF0);

        // Continuous contention for 40 cycles.
        do_reset();
        v0 = 1'b1; v1 = 1'b1; d0 = 8'h96; d1 = 8'h69;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (v0 && r0) begin acc_cyc.push_back(c); acc_who.push_back(0); end
            if (v1 && r1) begin acc_cyc.push_back(c); acc_who.push_back(1); end
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
        chk("rr.count", acc_cyc.size(), 4);
        for (int i = 0; i < acc_cyc.size(); i++) begin
            chk($sformatf("rr.cycle%0d", i), acc_cyc[i], 10 * i);
            chk($sformatf("rr.who%0d", i), acc_who[i], i % 2);
        end

        // Reset while the 4th bit of a req1 frame is on the line.
        do_reset();
        v1 = 1'b1; d1 = 8'hC3;
        #1;
        chk("mid.accept", r1, 1'b1);
        tick();
        v1 = 1'b0;
        tick(); tick(); tick();
        #1;
        chk_out("mid.bit3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        chk_out("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 8'h5A; d1 = 8'hC3;
        #1;
        chk("mid.after_ready0", r0, 1'b1);
        chk("mid.after_ready1", r1, 1'b0);
        chk("mid.after_done", dn, 1'b0);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        collect("mid.after", 1'b0, 8'h5A);

        // LSB-first instance; data changes after accept must not leak into the frame.
        do_reset();
        lv1 = 1'b1; ld1 = 8'h01; l_exp = 8'h01;
        #1;
        chk("lsb.accept1", lr1, 1'b1);
        chk("lsb.noaccept0", lr0, 1'b0);
        tick();
        lv1 = 1'b0; ld1 = 8'hFE;
        for (int k = 0; k < W; k++) begin
            #1;
            chk($sformatf("lsb1.bit%0d", k), lso, l_exp[k]);
            chk($sformatf("lsb1.frame%0d", k), lsf, 1'b1);
            chk($sformatf("lsb1.id%0d", k), lsid, 1'b1);
            tick();
        end
        #1;
        chk("lsb1.done", ldn, 1'b1);
        chk("lsb1.gap_frame", lsf, 1'b0);
        tick();
        lv0 = 1'b1; ld0 = 8'hB4; l_exp = 8'hB4;
        #1;
        chk("lsb.accept0", lr0, 1'b1);
        tick();
        lv0 = 1'b0; ld0 = 8'h00;
        for (int k = 0; k < W; k++) begin
            #1;
            chk($sformatf("lsb2.bit%0d", k), lso, l_exp[k]);
            chk($sformatf("lsb2.id%0d", k), lsid, 1'b0);
            tick();
        end
        #1;
        chk("lsb2.done", ldn, 1'b1);
        tick();

        // Random traffic against a frame-position model: m_pos 0 = idle,
        // 1..W = bit m_pos-1 of the frame on the line, W+1 = gap.
        do_reset();
        m_pos = 0; m_id = 0; m_last = 1; m_word = '0;
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            v0  = ($urandom_range(0, 3) != 0);
            v1  = ($urandom_range(0, 3) != 0);
            d0  = W'($urandom);
            d1  = W'($urandom);
            #1;
            e_r0 = 1'b0;
            e_r1 = 1'b0;
            if (!rst && m_pos == 0) begin
                if (v0 && v1) begin
                    if (m_last == 1) e_r0 = 1'b1; else e_r1 = 1'b1;
                end else begin
                    e_r0 = v0;
                    e_r1 = v1;
                end
            end
            e_frame = (m_pos >= 1 && m_pos <= W);
            e_out   = e_frame ? m_word[W - m_pos] : 1'b0;
            chk($sformatf("rnd%0d.ready0", c), r0, e_r0);
            chk($sformatf("rnd%0d.ready1", c), r1, e_r1);
            chk_out($sformatf("rnd%0d", c), e_out, e_frame, m_id[0], (m_pos == W + 1), (m_pos != 0));
            if (rst) begin
                m_pos = 0; m_id = 0; m_last = 1;
            end else if (m_pos == 0) begin
                if (e_r0 || e_r1) begin
                    m_word = e_r0 ? d0 : d1;
                    m_id   = e_r0 ? 0 : 1;
                    m_last = m_id;
                    m_pos  = 1;
                end
            end else begin
                m_pos = (m_pos == W + 1) ? 0 : m_pos + 1;
            end
            tick();
        end
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
